serial_adder: RTL and testbench

Bit-serial adder stage that feeds the team's 1-bit full-adder cell (FullAdderCell: a, b, cin -> sum, co) one operand bit pair per clock, LSB first, and registers its carry between cycles. It accepts two WIDTH-bit operands plus carry-in over a valid/ready handshake and returns a WIDTH-bit sum plus carry-out over a second valid/ready handshake. It is the area-minimal sequential counterpart to the ripple adder and uses one full-adder instance for any WIDTH.

---
 rtl/serial_adder_if.sv | 25 ++
 rtl/serial_adder.sv | 130 +++++++++++++
 tb/tb_serial_adder.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_if.sv
// Handshake bundle for serial_adder: operand request channel (in_*) and
// result response channel (out_*). The adder takes the slave side.
interface serial_adder_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell processes one operand bit pair per
// clock, LSB first, with the carry held in a register between cycles.
// Result is (a + b + cin) split into a WIDTH-bit sum and a carry-out.

// 1-bit full-adder cell shared by the serial datapath.
module FullAdderCell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic co
);
    // Pure combinational sum/carry of three bits.
    always_comb begin
        sum = a ^ b ^ cin;
        co  = (a & b) | (a & cin) | (b & cin);
    end
endmodule

module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input logic           clk,
    input logic           rst_n,
    serial_adder_if.slave bus
);
    localparam int unsigned    CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    if (WIDTH < 1 || WIDTH > 64) begin : g_width_check
        $error("serial_adder: WIDTH must be in 1..64");
    end

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_sr_q;
    logic [WIDTH-1:0] b_sr_q;
    logic [WIDTH-1:0] s_sr_q;
    logic [WIDTH-1:0] s_sr_d;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic             fa_sum;
    logic             fa_co;

    FullAdderCell u_fa (
        .a   (a_sr_q[0]),
        .b   (b_sr_q[0]),
        .cin (carry_q),
        .sum (fa_sum),
        .co  (fa_co)
    );

    // New sum bit enters at the MSB so that after WIDTH shifts bit 0 holds the LSB.
    if (WIDTH == 1) begin : g_s_w1
        always_comb s_sr_d = fa_sum;
    end else begin : g_s_wn
        always_comb s_sr_d = {fa_sum, s_sr_q[WIDTH-1:1]};
    end

    // Control FSM and datapath registers; handshake outputs are registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            a_sr_q      <= '0;
            b_sr_q      <= '0;
            s_sr_q      <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sr_q     <= bus.a;
                        b_sr_q     <= bus.b;
                        carry_q    <= bus.cin;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= SHIFT;
                    end
                end
                SHIFT: begin
                    s_sr_q  <= s_sr_d;
                    a_sr_q  <= a_sr_q >> 1;
                    b_sr_q  <= b_sr_q >> 1;
                    carry_q <= fa_co;
                    // Counter holds on the last bit so it never passes WIDTH-1.
                    if (cnt_q == LAST) begin
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = s_sr_q;
    assign bus.cout      = carry_q;

    // Both channels are never open at once, and the bit counter stays in range.
    a_no_overlap : assert property (@(posedge clk) disable iff (!rst_n)
        !(in_ready_q && out_valid_q));
    a_cnt_range : assert property (@(posedge clk) disable iff (!rst_n)
        cnt_q <= LAST);
endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;
    logic clk;
    logic rst_n;

    int vectors;
    int miscompares;

    serial_adder_if #(.WIDTH(8)) if8 ();
    serial_adder_if #(.WIDTH(1)) if1 ();

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if8.slave)
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: full-precision addition, split into {cout, sum}.
    function automatic logic [8:0] ref_add8(logic [7:0] x, logic [7:0] y, logic c);
        int unsigned t;
        t = int'(x) + int'(y) + int'(c);
        return t[8:0];
    endfunction

    // Waits (bounded) for in_ready, issues one operation with out_ready low and
    // returns the number of cycles from the accept cycle to the first out_valid cycle.
    task automatic do_op8(input logic [7:0] xa, input logic [7:0] xb, input logic xc,
                          output int lat, output bit ir_seen);
        int w;
        w = 0;
        ir_seen = 1'b0;
        while (!if8.in_ready && w < 40) begin
            tick();
            w++;
        end
        if8.a = xa;
        if8.b = xb;
        if8.cin = xc;
        if8.in_valid = 1'b1;
        if8.out_ready = 1'b0;
        tick();
        if8.in_valid = 1'b0;
        lat = 1;
        while (!if8.out_valid && lat < 40) begin
            if (if8.in_ready) ir_seen = 1'b1;
            tick();
            lat++;
        end
    endtask

    task automatic finish8();
        if8.out_ready = 1'b1;
        tick();
        if8.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        vectors++;
        if ({if8.in_ready, if8.out_valid, if8.sum, if8.cout} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_w8: got rdy=%b vld=%b sum=%h cout=%b, want rdy=1 vld=0 sum=00 cout=0",
                     if8.in_ready, if8.out_valid, if8.sum, if8.cout);
        end
        vectors++;
        if ({if1.in_ready, if1.out_valid, if1.sum, if1.cout} !== {1'b1, 1'b0, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_w1: got rdy=%b vld=%b sum=%b cout=%b, want 1 0 0 0",
                     if1.in_ready, if1.out_valid, if1.sum, if1.cout);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        int lat;
        bit irs;
        do_op8(8'h5A, 8'h3C, 1'b0, lat, irs);
        vectors++;
        if (lat !== 9) begin
            miscompares++;
            $display("FAIL basic_latency: got %0d cycles, want 9", lat);
        end
        vectors++;
        if ({if8.cout, if8.sum} !== 9'h096) begin
            miscompares++;
            $display("FAIL basic_sum: got cout=%b sum=%h, want cout=0 sum=96", if8.cout, if8.sum);
        end
        vectors++;
        if (irs !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_in_ready_busy: in_ready seen high while busy, want low");
        end
        finish8();
        vectors++;
        if ({if8.in_ready, if8.out_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL basic_return_idle: got rdy=%b vld=%b, want 1 0", if8.in_ready, if8.out_valid);
        end
    endtask

    task automatic test_carry();
        logic [7:0] ta[2];
        logic [7:0] tb_[2];
        logic       tc[2];
        logic [8:0] exp_v;
        int lat;
        bit irs;
        ta[0] = 8'hFF; tb_[0] = 8'h01; tc[0] = 1'b0;
        ta[1] = 8'hFF; tb_[1] = 8'hFF; tc[1] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            exp_v = ref_add8(ta[i], tb_[i], tc[i]);
            do_op8(ta[i], tb_[i], tc[i], lat, irs);
            vectors++;
            if ({if8.cout, if8.sum} !== exp_v) begin
                miscompares++;
                $display("FAIL carry_%0d: got cout=%b sum=%h, want cout=%b sum=%h",
                         i, if8.cout, if8.sum, exp_v[8], exp_v[7:0]);
            end
            finish8();
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] xa, xb;
        logic       xc;
        logic [8:0] exp_v;
        int lat;
        bit irs;
        xa = 8'($urandom);
        xb = 8'($urandom);
        xc = 1'($urandom);
        exp_v = ref_add8(xa, xb, xc);
        do_op8(xa, xb, xc, lat, irs);
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if ({if8.out_valid, if8.in_ready, if8.cout, if8.sum} !== {1'b1, 1'b0, exp_v}) begin
                miscompares++;
                $display("FAIL backpressure_hold_%0d: got vld=%b rdy=%b cout=%b sum=%h, want 1 0 %b %h",
                         i, if8.out_valid, if8.in_ready, if8.cout, if8.sum, exp_v[8], exp_v[7:0]);
            end
            if8.in_valid = ~if8.in_valid;
            if8.a = 8'($urandom);
            if8.b = 8'($urandom);
            if8.cin = 1'($urandom);
            tick();
        end
        if8.in_valid = 1'b0;
        finish8();
        vectors++;
        if ({if8.in_ready, if8.out_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL backpressure_release: got rdy=%b vld=%b, want 1 0", if8.in_ready, if8.out_valid);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        bit irs;
        if8.a = 8'hA7;
        if8.b = 8'h6E;
        if8.cin = 1'b1;
        if8.in_valid = 1'b1;
        tick();
        if8.in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        vectors++;
        if ({if8.in_ready, if8.out_valid, if8.sum, if8.cout} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_mid: got rdy=%b vld=%b sum=%h cout=%b, want 1 0 00 0",
                     if8.in_ready, if8.out_valid, if8.sum, if8.cout);
        end
        do_op8(8'h10, 8'h20, 1'b1, lat, irs);
        vectors++;
        if ({if8.cout, if8.sum} !== 9'h031 || lat !== 9) begin
            miscompares++;
            $display("FAIL reset_mid_after: got cout=%b sum=%h lat=%0d, want cout=0 sum=31 lat=9",
                     if8.cout, if8.sum, lat);
        end
        finish8();
    endtask

    task automatic test_back_to_back();
        logic [8:0] q_exp[$];
        logic [8:0] exp_v;
        int accepted, done, cyc, last_acc;
        accepted = 0;
        done = 0;
        cyc = 0;
        last_acc = -1;
        if8.out_ready = 1'b1;
        while (done < 1000 && cyc < 20000) begin
            if8.a = 8'($urandom);
            if8.b = 8'($urandom);
            if8.cin = 1'($urandom);
            if8.in_valid = (accepted < 1000);
            if (if8.in_ready && if8.out_valid) begin
                vectors++;
                miscompares++;
                $display("FAIL b2b_overlap: in_ready and out_valid both 1 at cycle %0d", cyc);
            end
            if (if8.in_ready && if8.in_valid) begin
                q_exp.push_back(ref_add8(if8.a, if8.b, if8.cin));
                if (last_acc >= 0) begin
                    vectors++;
                    if (cyc - last_acc !== 10) begin
                        miscompares++;
                        $display("FAIL b2b_interval: got %0d cycles between accepts, want 10", cyc - last_acc);
                    end
                end
                last_acc = cyc;
                accepted++;
            end
            if (if8.out_valid) begin
                exp_v = (q_exp.size() > 0) ? q_exp.pop_front() : 9'h1XX;
                vectors++;
                if ({if8.cout, if8.sum} !== exp_v) begin
                    miscompares++;
                    $display("FAIL b2b_result_%0d: got cout=%b sum=%h, want cout=%b sum=%h",
                             done, if8.cout, if8.sum, exp_v[8], exp_v[7:0]);
                end
                done++;
            end
            tick();
            cyc++;
        end
        vectors++;
        if (done !== 1000 || q_exp.size() !== 0) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d results with %0d pending, want 1000 and 0", done, q_exp.size());
        end
        if8.in_valid = 1'b0;
        if8.out_ready = 1'b0;
        tick();
    endtask

    task automatic test_width1();
        int lat;
        logic [1:0] exp_v;
        for (int v = 7; v >= 0; v--) begin
            if1.a = v[2];
            if1.b = v[1];
            if1.cin = v[0];
            exp_v = 2'(int'(v[2]) + int'(v[1]) + int'(v[0]));
            if1.in_valid = 1'b1;
            if1.out_ready = 1'b0;
            tick();
            if1.in_valid = 1'b0;
            lat = 1;
            while (!if1.out_valid && lat < 20) begin
                tick();
                lat++;
            end
            vectors++;
            if ({if1.cout, if1.sum} !== exp_v || lat !== 2) begin
                miscompares++;
                $display("FAIL width1_%0d: got cout=%b sum=%b lat=%0d, want cout=%b sum=%b lat=2",
                         v, if1.cout, if1.sum, lat, exp_v[1], exp_v[0]);
            end
            if1.out_ready = 1'b1;
            tick();
            if1.out_ready = 1'b0;
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        if8.in_valid = 1'b0;
        if8.a = '0;
        if8.b = '0;
        if8.cin = 1'b0;
        if8.out_ready = 1'b0;
        if1.in_valid = 1'b0;
        if1.a = '0;
        if1.b = '0;
        if1.cin = 1'b0;
        if1.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_carry();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_width1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
